mc_control: RTL and testbench

Multicycle main control FSM for the MIPS datapath. It produces the 2-bit ALUOp consumed by ALU_Control, plus every datapath mux select and write enable, sequencing each instruction through fetch, decode, execute, memory and writeback states. It sits between the instruction register (opcode field) and the datapath. It stalls on a simple memory-ready handshake.

---
 rtl/mc_control.sv | 167 ++++++++++++++++
 tb/tb_mc_control.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath select and write enable from the current state.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach MEMADR, so anything that is not lw is treated as sw.
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RTYPEWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUOp      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      // IR and PC only load once the instruction word is actually back.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTYPEWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each directed cycle pushes its expected output
// vector; a monitor on the falling edge pops and compares against the DUT.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcB, PCSrc;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegWrite, PCWrite;
  logic       Branch, RegDst, MemtoReg, instr_done, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .Branch(Branch), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  // {state, ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite, IRWrite,
  //  RegWrite, PCWrite, Branch, RegDst, MemtoReg, instr_done, illegal}
  localparam logic [21:0] V_FETCH_W = {4'd0,  2'b00, 1'b0, 2'b01, 2'b00, 10'b0100000000, 1'b0};
  localparam logic [21:0] V_FETCH_R = {4'd0,  2'b00, 1'b0, 2'b01, 2'b00, 10'b0101010000, 1'b0};
  localparam logic [21:0] V_DECODE  = {4'd1,  2'b00, 1'b0, 2'b11, 2'b00, 10'b0000000000, 1'b0};
  localparam logic [21:0] V_MEMADR  = {4'd2,  2'b00, 1'b1, 2'b10, 2'b00, 10'b0000000000, 1'b0};
  localparam logic [21:0] V_MEMRD   = {4'd3,  2'b00, 1'b0, 2'b00, 2'b00, 10'b1100000000, 1'b0};
  localparam logic [21:0] V_MEMWB   = {4'd4,  2'b00, 1'b0, 2'b00, 2'b00, 10'b0000100011, 1'b0};
  localparam logic [21:0] V_MEMWR_W = {4'd5,  2'b00, 1'b0, 2'b00, 2'b00, 10'b1010000000, 1'b0};
  localparam logic [21:0] V_MEMWR_R = {4'd5,  2'b00, 1'b0, 2'b00, 2'b00, 10'b1010000001, 1'b0};
  localparam logic [21:0] V_EXEC    = {4'd6,  2'b10, 1'b1, 2'b00, 2'b00, 10'b0000000000, 1'b0};
  localparam logic [21:0] V_RTYPEWB = {4'd7,  2'b00, 1'b0, 2'b00, 2'b00, 10'b0000100101, 1'b0};
  localparam logic [21:0] V_BEQ     = {4'd8,  2'b01, 1'b1, 2'b00, 2'b01, 10'b0000001001, 1'b0};
  localparam logic [21:0] V_ADDIEX  = {4'd9,  2'b00, 1'b1, 2'b10, 2'b00, 10'b0000000000, 1'b0};
  localparam logic [21:0] V_ADDIWB  = {4'd10, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000100001, 1'b0};
  localparam logic [21:0] V_JUMP    = {4'd11, 2'b00, 1'b0, 2'b00, 2'b10, 10'b0000010001, 1'b0};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic [21:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [21:0] act;
  assign act = {state, ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite,
                IRWrite, RegWrite, PCWrite, Branch, RegDst, MemtoReg, instr_done, illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h (state %0d vs %0d)",
                 e.tag, act, e.v, act[21:18], e.v[21:18]);
      end
    end
  end

  task automatic push(input logic [21:0] v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock: after the rising edge, drive inputs and record what this cycle must show.
  task automatic step(input logic [5:0] o, input logic mr, input logic [21:0] v,
                      input logic ill, input string tag);
    @(posedge clk);
    #1;
    op = o;
    mem_ready = mr;
    push(v | {21'b0, ill}, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    op = OP_R;
    mem_ready = 1'b0;
    push(V_FETCH_W, "reset_init");
    @(negedge clk);
    #2;
    reset = 1'b0;

    // lw, zero wait states: 5 cycles
    step(OP_LW, 1'b1, V_FETCH_R, 1'b0, "lw_fetch");
    step(OP_LW, 1'b1, V_DECODE,  1'b0, "lw_decode");
    step(OP_LW, 1'b1, V_MEMADR,  1'b0, "lw_memadr");
    step(OP_LW, 1'b1, V_MEMRD,   1'b0, "lw_memrd");
    step(OP_LW, 1'b1, V_MEMWB,   1'b0, "lw_memwb");

    // R-type: 4 cycles
    step(OP_R, 1'b1, V_FETCH_R, 1'b0, "r_fetch");
    step(OP_R, 1'b1, V_DECODE,  1'b0, "r_decode");
    step(OP_R, 1'b1, V_EXEC,    1'b0, "r_exec");
    step(OP_R, 1'b1, V_RTYPEWB, 1'b0, "r_wb");

    // beq: 3 cycles
    step(OP_BEQ, 1'b1, V_FETCH_R, 1'b0, "beq_fetch");
    step(OP_BEQ, 1'b1, V_DECODE,  1'b0, "beq_decode");
    step(OP_BEQ, 1'b1, V_BEQ,     1'b0, "beq_exec");

    // sw with two wait cycles in MEMWR: 6 cycles
    step(OP_SW, 1'b1, V_FETCH_R, 1'b0, "sw_fetch");
    step(OP_SW, 1'b1, V_DECODE,  1'b0, "sw_decode");
    step(OP_SW, 1'b1, V_MEMADR,  1'b0, "sw_memadr");
    step(OP_SW, 1'b0, V_MEMWR_W, 1'b0, "sw_wait1");
    step(OP_SW, 1'b0, V_MEMWR_W, 1'b0, "sw_wait2");
    step(OP_SW, 1'b1, V_MEMWR_R, 1'b0, "sw_done");

    // j: 3 cycles, with one fetch wait up front
    step(OP_J, 1'b0, V_FETCH_W, 1'b0, "j_fetch_wait");
    step(OP_J, 1'b1, V_FETCH_R, 1'b0, "j_fetch");
    step(OP_J, 1'b1, V_DECODE,  1'b0, "j_decode");
    step(OP_J, 1'b1, V_JUMP,    1'b0, "j_jump");

    // illegal opcode, then addi with illegal held
    step(OP_BAD,  1'b1, V_FETCH_R, 1'b0, "bad_fetch");
    step(OP_BAD,  1'b1, V_DECODE,  1'b0, "bad_decode");
    step(OP_ADDI, 1'b0, V_FETCH_W, 1'b1, "bad_after");
    step(OP_ADDI, 1'b1, V_FETCH_R, 1'b1, "addi_fetch");
    step(OP_ADDI, 1'b1, V_DECODE,  1'b1, "addi_decode");
    step(OP_ADDI, 1'b1, V_ADDIEX,  1'b1, "addi_ex");
    step(OP_ADDI, 1'b1, V_ADDIWB,  1'b1, "addi_wb");

    // R-type interrupted by reset between edges while in EXEC
    step(OP_R, 1'b1, V_FETCH_R, 1'b1, "rst_fetch");
    step(OP_R, 1'b1, V_DECODE,  1'b1, "rst_decode");
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    push(V_FETCH_W, "rst_mid_exec");
    step(OP_R, 1'b0, V_FETCH_W, 1'b0, "rst_held");
    @(negedge clk);
    #2;
    reset = 1'b0;

    // first instruction after reset
    step(OP_J, 1'b1, V_FETCH_R, 1'b0, "post_fetch");
    step(OP_J, 1'b1, V_DECODE,  1'b0, "post_decode");
    step(OP_J, 1'b1, V_JUMP,    1'b0, "post_jump");
    step(OP_J, 1'b0, V_FETCH_W, 1'b0, "post_idle");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
